// File: rtl/regfile_writeback_port_if.sv
// Bundle between the write-back port and its neighbours.
// master: MEM/WB, mul/div unit and ID-stage side; slave: write-back port.
interface regfile_writeback_port_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              PipeWrite;
  logic [ADDR_W-1:0] PipeReg;
  logic [DATA_W-1:0] PipeData;

  logic              MdValid;
  logic [ADDR_W-1:0] MdReg;
  logic [DATA_W-1:0] MdData;
  logic              MdReady;

  logic              MdIssue;
  logic [ADDR_W-1:0] MdIssueReg;

  logic [ADDR_W-1:0] RdCheck1;
  logic [ADDR_W-1:0] RdCheck2;
  logic              Busy1;
  logic              Busy2;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [CNT_W-1:0]  FifoCount;

  modport master (
    output PipeWrite, PipeReg, PipeData,
    output MdValid, MdReg, MdData,
    input  MdReady,
    output MdIssue, MdIssueReg,
    output RdCheck1, RdCheck2,
    input  Busy1, Busy2,
    input  RegWrite, WriteRegister, WriteData,
    input  FifoCount
  );

  modport slave (
    input  PipeWrite, PipeReg, PipeData,
    input  MdValid, MdReg, MdData,
    output MdReady,
    input  MdIssue, MdIssueReg,
    input  RdCheck1, RdCheck2,
    output Busy1, Busy2,
    output RegWrite, WriteRegister, WriteData,
    output FifoCount
  );
endinterface

// File: rtl/regfile_writeback_port.sv
// Sole writer of the register file: merges MEM/WB and mul/div results.
// Ports: Clk, Reset (sync, high), bus (slave) with pipe/md/scoreboard/rf.
module regfile_writeback_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic Clk,
  input logic Reset,
  regfile_writeback_port_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NREG  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } md_ent_t;

  md_ent_t           r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [NREG-1:0]   r_busy;
  logic              r_clr_vld;
  logic [ADDR_W-1:0] r_clr_reg;

  logic              r_we;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic              w_ready;
  logic              w_md_live;
  logic              w_empty;
  logic              w_pipe_req;
  logic              w_sel_pipe;
  logic              w_sel_fifo;
  logic              w_sel_byp;
  logic              w_enq;
  logic              w_deq;
  md_ent_t           w_head;
  md_ent_t           w_in;
  logic [ADDR_W-1:0] w_nxt_reg;
  logic [DATA_W-1:0] w_nxt_data;
  logic [CNT_W-1:0]  w_nxt_count;
  logic [NREG-1:0]   w_busy_nxt;

  function automatic logic [PTR_W-1:0] f_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_ready    = !Reset && (r_count < CNT_W'(FIFO_DEPTH));
  // Results to r0 finish the handshake but never reach the FIFO.
  assign w_md_live  = bus.MdValid && w_ready && (bus.MdReg != '0);
  assign w_empty    = (r_count == '0);
  assign w_pipe_req = bus.PipeWrite && (bus.PipeReg != '0);

  assign w_sel_pipe = w_pipe_req;
  assign w_sel_fifo = !w_pipe_req && !w_empty;
  assign w_sel_byp  = !w_pipe_req && w_empty && w_md_live;

  assign w_enq  = w_md_live && !w_sel_byp;
  assign w_deq  = w_sel_fifo;
  assign w_head = r_fifo[r_rd_ptr];
  assign w_in   = '{rd: bus.MdReg, data: bus.MdData};

  always_comb begin
    w_nxt_reg  = r_wreg;
    w_nxt_data = r_wdata;
    unique case (1'b1)
      w_sel_pipe: begin
        w_nxt_reg  = bus.PipeReg;
        w_nxt_data = bus.PipeData;
      end
      w_sel_fifo: begin
        w_nxt_reg  = w_head.rd;
        w_nxt_data = w_head.data;
      end
      w_sel_byp: begin
        w_nxt_reg  = bus.MdReg;
        w_nxt_data = bus.MdData;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nxt_count = r_count;
    unique case ({w_enq, w_deq})
      2'b10:   w_nxt_count = r_count + 1'b1;
      2'b01:   w_nxt_count = r_count - 1'b1;
      default: ;
    endcase
  end

  // Clear lands at the edge the file commits; a new issue overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_clr_vld)
      w_busy_nxt[r_clr_reg] = 1'b0;
    if (bus.MdIssue && (bus.MdIssueReg != '0))
      w_busy_nxt[bus.MdIssueReg] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (w_enq)
      r_fifo[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_we      <= 1'b0;
      r_wreg    <= '0;
      r_wdata   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      r_clr_vld <= 1'b0;
      r_clr_reg <= '0;
    end else begin
      r_we      <= w_sel_pipe | w_sel_fifo | w_sel_byp;
      r_wreg    <= w_nxt_reg;
      r_wdata   <= w_nxt_data;
      r_count   <= w_nxt_count;
      r_busy    <= w_busy_nxt;
      r_clr_vld <= w_sel_fifo | w_sel_byp;
      r_clr_reg <= w_nxt_reg;
      if (w_enq)
        r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_deq)
        r_rd_ptr <= f_inc(r_rd_ptr);
    end
  end

  assign bus.MdReady       = w_ready;
  assign bus.Busy1         = r_busy[bus.RdCheck1];
  assign bus.Busy2         = r_busy[bus.RdCheck2];
  assign bus.RegWrite      = r_we;
  assign bus.WriteRegister = r_wreg;
  assign bus.WriteData     = r_wdata;
  assign bus.FifoCount     = r_count;
endmodule
